// File: rtl/laser_pkg.sv
// Shared definitions for the LASER job controller: default sizing, the
// controller state encoding, the buffered point type and the squared-distance
// helper used by the optional coverage check (LASER_COVER_CHECK_EN).
package laser_pkg;

  localparam int CW      = 4;    // coordinate width
  localparam int NPTS    = 40;   // points per job
  localparam int RST_CYC = 2;    // LRST high time before loading
  localparam int MAX_CYC = 100;  // RUN budget before forcing a result
  localparam int R2      = 16;   // squared coverage radius

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    LOAD,
    RUN,
    CHECK,
    RESULT
  } state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } point_t;

  // Squared Euclidean distance between a point and a centre. Differences are
  // signed CW+1 bits; their magnitudes are squared unsigned so the sum fits
  // in 2*CW+1 bits without wrap.
  function automatic logic [2*CW:0] dist2(input point_t p,
                                          input logic [CW-1:0] cx,
                                          input logic [CW-1:0] cy);
    logic signed [CW:0] dx;
    logic signed [CW:0] dy;
    logic signed [CW:0] ndx;
    logic signed [CW:0] ndy;
    logic [CW-1:0]      ax;
    logic [CW-1:0]      ay;
    logic [2*CW-1:0]    sx;
    logic [2*CW-1:0]    sy;
    dx  = $signed({1'b0, p.x}) - $signed({1'b0, cx});
    dy  = $signed({1'b0, p.y}) - $signed({1'b0, cy});
    ndx = -dx;
    ndy = -dy;
    ax  = dx[CW] ? ndx[CW-1:0] : dx[CW-1:0];
    ay  = dy[CW] ? ndy[CW-1:0] : dy[CW-1:0];
    sx  = {{CW{1'b0}}, ax} * {{CW{1'b0}}, ax};
    sy  = {{CW{1'b0}}, ay} * {{CW{1'b0}}, ay};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_pt_buf.sv
// Job point buffer: N entries of {x, y} filled in order through a write
// pointer, with a combinational read port indexed by the controller.
// Contents are not reset; only the pointer (and hence FULL) is.
module laser_pt_buf
  import laser_pkg::*;
#(
  parameter  int N     = NPTS,
  localparam int PTR_W = $clog2(N + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WR,      // already qualified by the controller state
  input  logic             CLR,     // rewind for the next job
  input  point_t           WR_PT,
  input  logic [PTR_W-1:0] RD_IDX,
  output point_t           RD_PT,
  output logic             FULL
);

  point_t           mem [N];
  logic [PTR_W-1:0] wptr_reg;
  logic             wr_take;

  assign FULL    = (wptr_reg == PTR_W'(N));
  assign wr_take = WR && !FULL;
  assign RD_PT   = mem[RD_IDX];

  // Write pointer: advances on each accepted write, rewinds after a job.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_reg <= '0;
    end else if (CLR) begin
      wptr_reg <= '0;
    end else if (wr_take) begin
      wptr_reg <= wptr_reg + 1'b1;
    end
  end

  // Storage: a full buffer never overwrites an entry.
  always_ff @(posedge CLK) begin
    if (wr_take) begin
      mem[wptr_reg] <= WR_PT;
    end
  end

endmodule

// File: rtl/laser_job_ctrl.sv
// Job sequencer in front of one LASER coverage core. Buffers a host job,
// drives the core reset/load/run protocol with a RUN-cycle budget, latches
// the two centres and returns them over a valid/ready result port.
// Optional build macro LASER_COVER_CHECK_EN adds a CHECK pass that counts
// buffered points within radius of either centre and reports it on COVER.
module laser_job_ctrl #(
  parameter  int NPTS    = laser_pkg::NPTS,
  parameter  int RST_CYC = laser_pkg::RST_CYC,
  parameter  int MAX_CYC = laser_pkg::MAX_CYC,
`ifdef LASER_COVER_CHECK_EN
  parameter  int R2      = laser_pkg::R2,
`endif
  localparam int CW      = laser_pkg::CW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          WR_EN,
  input  logic [CW-1:0] WR_X,
  input  logic [CW-1:0] WR_Y,
  output logic          FULL,
  input  logic          START,
  output logic          BUSY,
  output logic          LRST,
  output logic [CW-1:0] LX,
  output logic [CW-1:0] LY,
  input  logic [CW-1:0] LC1X,
  input  logic [CW-1:0] LC1Y,
  input  logic [CW-1:0] LC2X,
  input  logic [CW-1:0] LC2Y,
  input  logic          LDONE,
  output logic [CW-1:0] RES_C1X,
  output logic [CW-1:0] RES_C1Y,
  output logic [CW-1:0] RES_C2X,
  output logic [CW-1:0] RES_C2Y,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic          TIMEOUT,
  output logic          PROTO_ERR
`ifdef LASER_COVER_CHECK_EN
  ,
  output logic [5:0]    COVER
`endif
);

  import laser_pkg::*;

  localparam int PTR_W = $clog2(NPTS + 1);
  localparam int RUN_W = $clog2(MAX_CYC + 2);
  localparam int CNT_W = (PTR_W > RUN_W) ? PTR_W : RUN_W;

`ifdef LASER_COVER_CHECK_EN
  localparam state_t          AFTER_RUN = CHECK;
  localparam logic [2*CW:0]   R2_V      = (2*CW+1)'(R2);
`else
  localparam state_t          AFTER_RUN = RESULT;
`endif

  state_t         state_reg, state_next;
  // One counter serves RESET length, LOAD/CHECK index and RUN budget.
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CW-1:0]  res_c1x_reg, res_c1x_next;
  logic [CW-1:0]  res_c1y_reg, res_c1y_next;
  logic [CW-1:0]  res_c2x_reg, res_c2x_next;
  logic [CW-1:0]  res_c2y_reg, res_c2y_next;
  logic           timeout_reg, timeout_next;
  logic           proto_err_reg, proto_err_next;
  logic           latch_res;
  logic           buf_wr;
  logic           buf_clr;
  logic           buf_full;
  logic           start_ok;
  point_t         wr_pt;
  point_t         rd_pt;

`ifdef LASER_COVER_CHECK_EN
  logic [5:0]     cover_reg, cover_next;
  logic [2*CW:0]  d1;
  logic [2*CW:0]  d2;
  logic           pt_hit;

  assign d1     = dist2(rd_pt, res_c1x_reg, res_c1y_reg);
  assign d2     = dist2(rd_pt, res_c2x_reg, res_c2y_reg);
  assign pt_hit = (d1 <= R2_V) || (d2 <= R2_V);
  assign COVER  = cover_reg;
`endif

  assign wr_pt.x  = WR_X;
  assign wr_pt.y  = WR_Y;
  // Writes only land while idle; the buffer itself refuses them when full.
  assign buf_wr   = WR_EN && (state_reg == IDLE);
  // A START coinciding with the final write sees FULL still low and is dropped.
  assign start_ok = START && (state_reg == IDLE) && buf_full;

  laser_pt_buf #(
    .N (NPTS)
  ) u_buf (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .WR     (buf_wr),
    .CLR    (buf_clr),
    .WR_PT  (wr_pt),
    .RD_IDX (cnt_reg[PTR_W-1:0]),
    .RD_PT  (rd_pt),
    .FULL   (buf_full)
  );

  // Outputs decoded from state so an asynchronous reset clears them at once.
  assign FULL      = buf_full;
  assign BUSY      = (state_reg != IDLE);
  assign LRST      = (state_reg == RESET);
  assign LX        = (state_reg == LOAD) ? rd_pt.x : '0;
  assign LY        = (state_reg == LOAD) ? rd_pt.y : '0;
  assign RES_VALID = (state_reg == RESULT);
  assign RES_C1X   = res_c1x_reg;
  assign RES_C1Y   = res_c1y_reg;
  assign RES_C2X   = res_c2x_reg;
  assign RES_C2Y   = res_c2y_reg;
  assign TIMEOUT   = timeout_reg;
  assign PROTO_ERR = proto_err_reg;

  // Next-state, counter, result-latch and flag logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    timeout_next   = timeout_reg;
    proto_err_next = proto_err_reg;
    latch_res      = 1'b0;
    buf_clr        = 1'b0;
`ifdef LASER_COVER_CHECK_EN
    cover_next     = cover_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = RESET;
          cnt_next   = '0;
`ifdef LASER_COVER_CHECK_EN
          cover_next = '0;
`endif
        end
      end
      RESET: begin
        if (LDONE) begin
          latch_res      = 1'b1;
          proto_err_next = 1'b1;
          state_next     = RESULT;
          cnt_next       = '0;
        end else if (cnt_reg == CNT_W'(RST_CYC - 1)) begin
          state_next = LOAD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LOAD: begin
        if (LDONE) begin
          latch_res      = 1'b1;
          proto_err_next = 1'b1;
          state_next     = RESULT;
          cnt_next       = '0;
        end else if (cnt_reg == CNT_W'(NPTS - 1)) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        // The last budgeted cycle forces a result if the core is still silent.
        if (LDONE || (cnt_reg == CNT_W'(MAX_CYC))) begin
          latch_res    = 1'b1;
          timeout_next = !LDONE;
          state_next   = AFTER_RUN;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef LASER_COVER_CHECK_EN
      CHECK: begin
        if (pt_hit) begin
          cover_next = cover_reg + 6'd1;
        end
        if (cnt_reg == CNT_W'(NPTS - 1)) begin
          state_next = RESULT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      RESULT: begin
        if (RES_READY) begin
          state_next     = IDLE;
          timeout_next   = 1'b0;
          proto_err_next = 1'b0;
          buf_clr        = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    res_c1x_next = latch_res ? LC1X : res_c1x_reg;
    res_c1y_next = latch_res ? LC1Y : res_c1y_reg;
    res_c2x_next = latch_res ? LC2X : res_c2x_reg;
    res_c2y_next = latch_res ? LC2Y : res_c2y_reg;
  end

  // Controller state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      res_c1x_reg   <= '0;
      res_c1y_reg   <= '0;
      res_c2x_reg   <= '0;
      res_c2y_reg   <= '0;
      timeout_reg   <= 1'b0;
      proto_err_reg <= 1'b0;
`ifdef LASER_COVER_CHECK_EN
      cover_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      res_c1x_reg   <= res_c1x_next;
      res_c1y_reg   <= res_c1y_next;
      res_c2x_reg   <= res_c2x_next;
      res_c2y_reg   <= res_c2y_next;
      timeout_reg   <= timeout_next;
      proto_err_reg <= proto_err_next;
`ifdef LASER_COVER_CHECK_EN
      cover_reg     <= cover_next;
`endif
    end
  end

endmodule

// File: tb/tb_laser_job_ctrl.sv
// Directed bench for laser_job_ctrl: buffer fill rules, reset/load/run
// sequencing, timeout, protocol error, result hold, mid-job reset and,
// when LASER_COVER_CHECK_EN is defined, the coverage count.
module tb_laser_job_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       WR_EN = 1'b0;
  logic [3:0] WR_X = '0;
  logic [3:0] WR_Y = '0;
  logic       START = 1'b0;
  logic [3:0] LC1X = '0;
  logic [3:0] LC1Y = '0;
  logic [3:0] LC2X = '0;
  logic [3:0] LC2Y = '0;
  logic       LDONE = 1'b0;
  logic       RES_READY = 1'b0;
  logic       FULL, BUSY, LRST, RES_VALID, TIMEOUT, PROTO_ERR;
  logic [3:0] LX, LY, RES_C1X, RES_C1Y, RES_C2X, RES_C2Y;
`ifdef LASER_COVER_CHECK_EN
  logic [5:0] COVER;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [3:0] px [40];
  logic [3:0] py [40];

  laser_job_ctrl dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WR_EN     (WR_EN),
    .WR_X      (WR_X),
    .WR_Y      (WR_Y),
    .FULL      (FULL),
    .START     (START),
    .BUSY      (BUSY),
    .LRST      (LRST),
    .LX        (LX),
    .LY        (LY),
    .LC1X      (LC1X),
    .LC1Y      (LC1Y),
    .LC2X      (LC2X),
    .LC2Y      (LC2Y),
    .LDONE     (LDONE),
    .RES_C1X   (RES_C1X),
    .RES_C1Y   (RES_C1Y),
    .RES_C2X   (RES_C2X),
    .RES_C2Y   (RES_C2Y),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .TIMEOUT   (TIMEOUT),
    .PROTO_ERR (PROTO_ERR)
`ifdef LASER_COVER_CHECK_EN
    ,
    .COVER     (COVER)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_pt(input logic [3:0] x, input logic [3:0] y);
    WR_EN = 1'b1;
    WR_X  = x;
    WR_Y  = y;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic write_job();
    for (int k = 0; k < 40; k++) write_pt(px[k], py[k]);
  endtask

  task automatic set_lc(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    LC1X = a; LC1Y = b; LC2X = c; LC2Y = d;
  endtask

  // START, then follow RESET and LOAD; returns in the first RUN cycle.
  task automatic launch();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("busy_after_start", BUSY, 1);
    chk("lrst_cyc0", LRST, 1);
    tick();
    chk("lrst_cyc1", LRST, 1);
    tick();
    for (int k = 0; k < 40; k++) begin
      chk("load_lrst", LRST, 0);
      chk("load_lx", LX, px[k]);
      chk("load_ly", LY, py[k]);
      tick();
    end
    chk("run_lx_zero", LX, 0);
    chk("run_ly_zero", LY, 0);
  endtask

  task automatic handshake();
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    chk("hs_valid", RES_VALID, 0);
    chk("hs_busy", BUSY, 0);
    chk("hs_full", FULL, 0);
    chk("hs_timeout", TIMEOUT, 0);
    chk("hs_proto", PROTO_ERR, 0);
  endtask

  initial begin
    // ---- reset state
    repeat (2) tick();
    chk("rst_full", FULL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_lrst", LRST, 0);
    chk("rst_lx", LX, 0);
    chk("rst_ly", LY, 0);
    chk("rst_valid", RES_VALID, 0);
    chk("rst_timeout", TIMEOUT, 0);
    chk("rst_proto", PROTO_ERR, 0);
    chk("rst_c1x", RES_C1X, 0);
    chk("rst_c2y", RES_C2Y, 0);
`ifdef LASER_COVER_CHECK_EN
    chk("rst_cover", COVER, 0);
`endif
    RST_N = 1'b1;
    tick();

    // ---- job 1: normal completion 10 cycles into RUN
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'(k % 16);
      py[k] = 4'(k / 16);
    end
    write_job();
    chk("j1_full", FULL, 1);
    chk("j1_idle_busy", BUSY, 0);
    launch();
    for (int c = 0; c < 10; c++) begin
      chk("j1_run_valid", RES_VALID, 0);
      tick();
    end
    LDONE = 1'b1;
    set_lc(4'd3, 4'd4, 4'd11, 4'd9);
    tick();
    LDONE = 1'b0;
    set_lc(4'd0, 4'd0, 4'd0, 4'd0);
`ifdef LASER_COVER_CHECK_EN
    repeat (40) tick();
`endif
    chk("j1_valid", RES_VALID, 1);
    chk("j1_c1x", RES_C1X, 3);
    chk("j1_c1y", RES_C1Y, 4);
    chk("j1_c2x", RES_C2X, 11);
    chk("j1_c2y", RES_C2Y, 9);
    chk("j1_timeout", TIMEOUT, 0);
    chk("j1_proto", PROTO_ERR, 0);
    chk("j1_busy", BUSY, 1);
    $display("job1 C1=(%0d,%0d) C2=(%0d,%0d) timeout=%0d", RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, TIMEOUT);
    handshake();

    // ---- job 2: core never finishes, result forced after 101 RUN cycles
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'((k * 7) % 16);
      py[k] = 4'(15 - (k % 16));
    end
    write_job();
    launch();
    for (int c = 0; c <= 100; c++) begin
      set_lc(4'(c % 16), 4'((c + 1) % 16), 4'((c + 2) % 16), 4'((c + 3) % 16));
      chk("j2_run_valid", RES_VALID, 0);
      tick();
    end
    set_lc(4'd0, 4'd0, 4'd0, 4'd0);
`ifdef LASER_COVER_CHECK_EN
    repeat (40) tick();
`endif
    chk("j2_valid", RES_VALID, 1);
    chk("j2_timeout", TIMEOUT, 1);
    chk("j2_proto", PROTO_ERR, 0);
    chk("j2_c1x", RES_C1X, 4);
    chk("j2_c1y", RES_C1Y, 5);
    chk("j2_c2x", RES_C2X, 6);
    chk("j2_c2y", RES_C2Y, 7);
    $display("job2 C1=(%0d,%0d) C2=(%0d,%0d) timeout=%0d", RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, TIMEOUT);
    handshake();

    // ---- job 3: LDONE in LOAD cycle 5, RES_READY already high
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'((k + 5) % 16);
      py[k] = 4'((k * 3) % 16);
    end
    write_job();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (2) tick();
    repeat (5) tick();
    chk("j3_load5_lx", LX, px[5]);
    LDONE = 1'b1;
    RES_READY = 1'b1;
    set_lc(4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    LDONE = 1'b0;
    set_lc(4'd0, 4'd0, 4'd0, 4'd0);
    chk("j3_valid", RES_VALID, 1);
    chk("j3_proto", PROTO_ERR, 1);
    chk("j3_timeout", TIMEOUT, 0);
    chk("j3_lx", LX, 0);
    chk("j3_c1x", RES_C1X, 1);
    chk("j3_c1y", RES_C1Y, 2);
    chk("j3_c2x", RES_C2X, 3);
    chk("j3_c2y", RES_C2Y, 4);
    $display("job3 C1=(%0d,%0d) C2=(%0d,%0d) proto_err=%0d", RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, PROTO_ERR);
    tick();
    RES_READY = 1'b0;
    chk("j3_hs_valid", RES_VALID, 0);
    chk("j3_hs_busy", BUSY, 0);
    chk("j3_hs_full", FULL, 0);
    chk("j3_hs_proto", PROTO_ERR, 0);

    // ---- job 4: START rules at the fill boundary, overflow write ignored
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'(15 - (k % 16));
      py[k] = 4'(k / 4);
    end
    for (int k = 0; k < 39; k++) write_pt(px[k], py[k]);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("j4_start39_busy", BUSY, 0);
    chk("j4_start39_lrst", LRST, 0);
    chk("j4_start39_full", FULL, 0);
    WR_EN = 1'b1;
    WR_X  = px[39];
    WR_Y  = py[39];
    START = 1'b1;
    tick();
    WR_EN = 1'b0;
    START = 1'b0;
    chk("j4_last_full", FULL, 1);
    chk("j4_last_busy", BUSY, 0);
    write_pt(~px[0], ~py[0]);
    chk("j4_extra_full", FULL, 1);
    chk("j4_extra_busy", BUSY, 0);
    launch();
    LDONE = 1'b1;
    set_lc(4'd5, 4'd6, 4'd7, 4'd8);
    tick();
    LDONE = 1'b0;
`ifdef LASER_COVER_CHECK_EN
    repeat (40) tick();
`endif
    // ---- result held while host stalls
    for (int i = 0; i < 20; i++) begin
      set_lc(4'($urandom_range(15)), 4'($urandom_range(15)),
             4'($urandom_range(15)), 4'($urandom_range(15)));
      chk("j4_hold_valid", RES_VALID, 1);
      chk("j4_hold_c1x", RES_C1X, 5);
      chk("j4_hold_c1y", RES_C1Y, 6);
      chk("j4_hold_c2x", RES_C2X, 7);
      chk("j4_hold_c2y", RES_C2Y, 8);
      tick();
    end
    set_lc(4'd0, 4'd0, 4'd0, 4'd0);
    $display("job4 C1=(%0d,%0d) C2=(%0d,%0d) held 20 cycles", RES_C1X, RES_C1Y, RES_C2X, RES_C2Y);
    handshake();

    // ---- job 5: asynchronous reset in the middle of LOAD
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'((k % 15) + 1);
      py[k] = 4'((k % 15) + 1);
    end
    write_job();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (2) tick();
    repeat (10) tick();
    chk("j5_load10_lx", LX, px[10]);
    RST_N = 1'b0;
    #1;
    chk("j5_arst_lrst", LRST, 0);
    chk("j5_arst_lx", LX, 0);
    chk("j5_arst_ly", LY, 0);
    chk("j5_arst_busy", BUSY, 0);
    chk("j5_arst_full", FULL, 0);
    chk("j5_arst_valid", RES_VALID, 0);
    chk("j5_arst_c1x", RES_C1X, 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("j5_post_full", FULL, 0);
    chk("j5_post_busy", BUSY, 0);
    $display("job5 aborted by reset during LOAD");

`ifdef LASER_COVER_CHECK_EN
    // ---- coverage: all points inside C1 at exactly R2
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'd0;
      py[k] = 4'd0;
    end
    write_job();
    launch();
    LDONE = 1'b1;
    set_lc(4'd4, 4'd0, 4'd15, 4'd15);
    tick();
    LDONE = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("c1_check_valid", RES_VALID, 0);
      tick();
    end
    chk("c1_valid", RES_VALID, 1);
    chk("c1_cover", COVER, 40);
    $display("cover job1 COVER=%0d", COVER);
    handshake();

    // ---- coverage: nothing covered
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'd15;
      py[k] = 4'd0;
    end
    write_job();
    launch();
    LDONE = 1'b1;
    set_lc(4'd0, 4'd15, 4'd0, 4'd15);
    tick();
    LDONE = 1'b0;
    repeat (40) tick();
    chk("c2_valid", RES_VALID, 1);
    chk("c2_cover", COVER, 0);
    $display("cover job2 COVER=%0d", COVER);
    handshake();

    // ---- coverage: x=0..4 of each 16-run lies within radius of (0,0)
    for (int k = 0; k < 40; k++) begin
      px[k] = 4'(k % 16);
      py[k] = 4'd0;
    end
    write_job();
    launch();
    LDONE = 1'b1;
    set_lc(4'd0, 4'd0, 4'd15, 4'd15);
    tick();
    LDONE = 1'b0;
    set_lc(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (40) tick();
    chk("c3_valid", RES_VALID, 1);
    chk("c3_cover", COVER, 15);
    $display("cover job3 COVER=%0d", COVER);
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_job_ctrl.md
Name: laser_job_ctrl

Overview:
- Sequencer in front of the LASER coverage core (40 points in, two radius-4 circle centres C1/C2 out, DONE when finished).
- Buffers one 40-point job written by a host, then drives the core's reset/load/run protocol with a timeout.
- Latches C1/C2 and hands them back to the host over a valid/ready result port.
- Sits between the host register interface and one LASER instance.

Parameters:
- NPTS, 40, points per job
- CW, 4, coordinate width in bits
- RST_CYC, 2, cycles LRST is held high before loading
- MAX_CYC, 100, RUN-state cycle budget before timeout
- R2, 16, squared coverage radius (used by optional check only)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  asynchronous active-low reset
- WR_EN  in  1  write one point into the job buffer
- WR_X  in  CW  point X
- WR_Y  in  CW  point Y
- FULL  out  1  buffer holds NPTS points
- START  in  1  launch job; accepted only in IDLE with FULL=1
- BUSY  out  1  high from START acceptance until result handshake completes
- LRST  out  1  active-high reset to the core
- LX  out  CW  point X to the core
- LY  out  CW  point Y to the core
- LC1X, LC1Y, LC2X, LC2Y  in  CW each  core result centres
- LDONE  in  1  core done
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  CW each  latched result
- RES_VALID  out  1  result available
- RES_READY  in  1  host accepts result
- TIMEOUT  out  1  result was forced after MAX_CYC; qualified by RES_VALID
- PROTO_ERR  out  1  LDONE was seen during RESET or LOAD; qualified by RES_VALID

Behaviour:
- Reset (RST_N=0, immediate):
  - State IDLE; write pointer 0.
  - FULL, BUSY, LRST, LX, LY, RES_*, RES_VALID, TIMEOUT and PROTO_ERR all 0.
  - Buffer contents don't-care.
- Buffer writes:
  - Honoured only in IDLE with FULL=0. Entry [wptr] is written and wptr increments; FULL=1 once wptr==NPTS.
  - WR_EN while FULL=1 or not in IDLE is ignored; no overwrite.
- START:
  - START and WR_EN in the same cycle with wptr==NPTS-1: the write is taken, START is ignored.
  - START while FULL=0 is ignored.
- IDLE -> RESET on an accepted START. BUSY rises the next cycle.
- RESET:
  - LRST=1 for exactly RST_CYC cycles, then -> LOAD. LRST drops in the first LOAD cycle.
- LOAD:
  - NPTS cycles; cycle k drives LX/LY = buffer[k], k = 0..NPTS-1. Then -> RUN.
  - LX/LY hold 0 outside LOAD.
- RUN:
  - Cycle counter counts from 0. The first cycle with LDONE=1 latches LC* into RES_*, then -> CHECK (when the optional feature is compiled in) or RESULT.
  - If the counter exceeds MAX_CYC without LDONE: latch LC* anyway, set TIMEOUT=1, proceed the same way.
- LDONE=1 during RESET or LOAD: set PROTO_ERR=1, latch LC*, go directly to RESULT.
- RESULT:
  - RES_VALID=1; RES_* and the flags are stable until the handshake.
  - RES_VALID & RES_READY in the same cycle: next cycle -> IDLE, RES_VALID=0, BUSY=0, wptr=0, FULL=0, TIMEOUT=0, PROTO_ERR=0.
  - RES_READY held high before RESULT completes the handshake in the first RESULT cycle.
- Width rules: counters are sized to hold NPTS and MAX_CYC+1 without wrap. No coordinate arithmetic outside the optional feature.
- RST_N asserted mid-job: everything returns to reset values, the buffer is discarded, and LRST is 0 during reset.

Optional Feature:
- Macro: LASER_COVER_CHECK_EN.
- When defined:
  - Adds output COVER (6 bits) and state CHECK entered after RUN.
  - CHECK scans buffer[0..NPTS-1], one point per cycle, for NPTS cycles.
  - Differences are signed CW+1 bits, squares are unsigned, each sum is 9 bits. A point is counted if d1<=R2 or d2<=R2.
  - Then -> RESULT, with COVER valid alongside RES_VALID. COVER resets to 0.
- When undefined: no CHECK state and no COVER port; RUN -> RESULT directly.

Decomposition:
- Package laser_pkg holds:
  - CW, NPTS, MAX_CYC and R2 defaults.
  - State enum {IDLE, RESET, LOAD, RUN, CHECK, RESULT}.
  - Point struct {x, y}.
- One sub-module, laser_pt_buf:
  - NPTS x (2*CW) register file with write pointer and FULL.
  - Combinational read port indexed by the controller.

Test Plan:
1. Write 40 points (k%16, k/16 ... ), START; core model raises LDONE 10 cycles into RUN with C1=(3,4), C2=(11,9) -> LRST high 2 cycles, LX/LY match buffer order over 40 cycles, RES_VALID with (3,4)/(11,9), TIMEOUT=0.
2. Core never raises LDONE -> after 101 RUN cycles RES_VALID=1, TIMEOUT=1, RES_* equal the LC* values at that cycle.
3. LDONE pulsed in LOAD cycle 5 -> PROTO_ERR=1, RES_VALID next cycle, no RUN state.
4. 39 writes then START alone -> ignored. 40th write plus START in one cycle -> START ignored, FULL=1. 41st write -> ignored (read back via LOAD order).
5. RES_READY held 0 for 20 cycles -> RES_* stable. Then RES_READY=1 -> IDLE, FULL=0, BUSY=0. RST_N pulse mid-LOAD -> all outputs 0 immediately.
6. (LASER_COVER_CHECK_EN) all 40 points at (0,0), C1=(4,0), C2=(15,15) -> COVER=40. Points at (15,0), C1=C2=(0,15) -> COVER=0.
